// File: rtl/spectrum_fb_writer_pkg.sv
// Shared types, colours and address helpers for the spectrum bar-graph framebuffer writer.
package spectrum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RENDER,
    ST_DONE
  } state_t;

  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;

  localparam int unsigned FB_ROW_SHIFT = 10;

  // Rows are 1 KiB apart; pixels are 2 bytes, so x must stay below 512.
  function automatic logic [31:0] fb_offset(input logic [7:0] y, input logic [8:0] x);
    return ({24'd0, y} << FB_ROW_SHIFT) | ({23'd0, x} << 1);
  endfunction

  function automatic logic [7:0] clamp_height(input logic [7:0] top, input logic [7:0] v_res);
    return (top > v_res) ? v_res : top;
  endfunction

endpackage

// File: rtl/spectrum_fb_writer_if.sv
// Magnitude stream and Avalon-MM write bus bundles used by spectrum_fb_writer.
interface spectrum_bin_if #(
  parameter int MAG_W = 16
);
  logic             bin_valid;
  logic             bin_ready;
  logic [MAG_W-1:0] bin_mag;

  modport master (output bin_valid, output bin_mag, input bin_ready);
  modport slave  (input bin_valid, input bin_mag, output bin_ready);
endinterface

interface spectrum_avm_if;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic        avm_waitrequest;

  modport master (output avm_address, output avm_write, output avm_writedata,
                  output avm_byteenable, input avm_waitrequest);
  modport slave  (input avm_address, input avm_write, input avm_writedata,
                  input avm_byteenable, output avm_waitrequest);
endinterface

// File: rtl/spectrum_fb_writer_raster_cnt.sv
// Raster walker: x/y position plus incremental bar index and column-within-bar, so no divider is needed.
module spectrum_raster_cnt #(
  parameter int NUM_BARS = 32,
  parameter int BAR_W    = 10,
  parameter int H_RES    = 320,
  parameter int V_RES    = 240
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clear,
  input  logic       i_advance,
  output logic [8:0] o_x,
  output logic [7:0] o_y,
  output logic [8:0] o_bar,
  output logic       o_last,
  output logic       o_in_bar
);

  localparam int COL_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [8:0]       r_x;
  logic [7:0]       r_y;
  logic [8:0]       r_bar;
  logic [COL_W-1:0] r_col;
  logic             w_row_end;
  logic             w_bar_end;

  assign w_row_end = (r_x == 9'(H_RES - 1));
  assign w_bar_end = (r_col == COL_W'(BAR_W - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_bar <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_x   <= '0;
      r_y   <= '0;
      r_bar <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (w_row_end) begin
        r_x   <= '0;
        r_bar <= '0;
        r_col <= '0;
        r_y   <= o_last ? '0 : r_y + 8'd1;
      end else begin
        r_x <= r_x + 9'd1;
        if (w_bar_end) begin
          r_col <= '0;
          r_bar <= r_bar + 9'd1;
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_bar    = r_bar;
  assign o_last   = w_row_end && (r_y == 8'(V_RES - 1));
  assign o_in_bar = (r_bar < 9'(NUM_BARS));

endmodule

// File: rtl/spectrum_fb_writer.sv
// Loads NUM_BARS magnitudes, then writes one full bar-graph frame to SDRAM in raster order.
// Optional SPECTRUM_PEAK_HOLD_EN adds a decaying white peak marker per bar.
module spectrum_fb_writer
  import spectrum_pkg::*;
#(
  parameter int          NUM_BARS = 32,
  parameter int          BAR_W    = 10,
  parameter int          H_RES    = 320,
  parameter int          V_RES    = 240,
  parameter int          MAG_W    = 16,
  parameter logic [31:0] FB_BASE  = 32'h0000_0000,
  parameter logic [15:0] BAR_RGB  = RGB_GREEN,
  parameter logic [15:0] BG_RGB   = RGB_BLACK
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 frame_start,
  spectrum_bin_if.slave        bin,
  spectrum_avm_if.master       avm,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_height [NUM_BARS];

  logic       w_bin_ready;
  logic       w_avm_write;
  logic       w_busy;
  logic       w_frame_done;
  logic       w_start;
  logic       w_beat;
  logic       w_last_beat;
  logic       w_accept;
  logic [7:0] w_mag_top;
  logic [7:0] w_new_h;

  logic [8:0]       w_x;
  logic [7:0]       w_y;
  logic [8:0]       w_bar;
  logic             w_last_px;
  logic             w_in_bar;
  logic [IDX_W-1:0] w_bar_idx;
  logic [7:0]       w_row;
  logic [7:0]       w_h_sel;
  logic             w_is_bar;
  logic             w_is_peak;
  logic [15:0]      w_colour;

  assign w_start     = (r_state == ST_IDLE) && frame_start;
  assign w_beat      = bin.bin_valid && w_bin_ready;
  assign w_last_beat = (r_idx == IDX_W'(NUM_BARS - 1));
  assign w_accept    = w_avm_write && !avm.avm_waitrequest;
  // Top byte of the magnitude is the height in pixels.
  assign w_mag_top   = 8'(bin.bin_mag >> (MAG_W - 8));
  assign w_new_h     = clamp_height(w_mag_top, 8'(V_RES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_bin_ready  = 1'b0;
    w_avm_write  = 1'b0;
    w_busy       = 1'b1;
    w_frame_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (frame_start) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_bin_ready = 1'b1;
        if (bin.bin_valid && w_last_beat) w_state_next = ST_RENDER;
      end
      ST_RENDER: begin
        w_avm_write = 1'b1;
        if (!avm.avm_waitrequest && w_last_px) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_frame_done = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= '0;
      for (int i = 0; i < NUM_BARS; i++) r_height[i] <= '0;
    end else begin
      if (w_start)     r_idx <= '0;
      else if (w_beat) r_idx <= r_idx + 1'b1;
      if (w_beat) r_height[r_idx] <= w_new_h;
    end
  end

  spectrum_raster_cnt #(
    .NUM_BARS (NUM_BARS),
    .BAR_W    (BAR_W),
    .H_RES    (H_RES),
    .V_RES    (V_RES)
  ) u_raster (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (w_start),
    .i_advance (w_accept),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_bar     (w_bar),
    .o_last    (w_last_px),
    .o_in_bar  (w_in_bar)
  );

  assign w_bar_idx = IDX_W'(w_bar);
  assign w_row     = 8'(V_RES - 1) - w_y;
  assign w_h_sel   = r_height[w_bar_idx];
  assign w_is_bar  = w_in_bar && (w_row < w_h_sel);

`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [7:0] r_peak    [NUM_BARS];
  logic [7:0] w_h_eff   [NUM_BARS];
  logic [7:0] w_pk_dec  [NUM_BARS];
  logic [7:0] w_pk_sel;
  logic       w_enter_render;

  assign w_enter_render = w_beat && w_last_beat;

  // The last bar's height lands in the same cycle the peaks update, so bypass it.
  for (genvar gi = 0; gi < NUM_BARS; gi++) begin : g_peak
    assign w_h_eff[gi]  = (w_beat && (r_idx == IDX_W'(gi))) ? w_new_h : r_height[gi];
    assign w_pk_dec[gi] = (r_peak[gi] == 8'd0) ? 8'd0 : r_peak[gi] - 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BARS; i++) r_peak[i] <= '0;
    end else if (w_enter_render) begin
      for (int i = 0; i < NUM_BARS; i++)
        r_peak[i] <= (w_h_eff[i] > w_pk_dec[i]) ? w_h_eff[i] : w_pk_dec[i];
    end
  end

  assign w_pk_sel  = r_peak[w_bar_idx];
  assign w_is_peak = w_in_bar && (w_pk_sel != 8'd0) && (w_row == w_pk_sel - 8'd1);
`else
  assign w_is_peak = 1'b0;
`endif

  assign w_colour = w_is_peak ? RGB_WHITE : (w_is_bar ? BAR_RGB : BG_RGB);

  assign bin.bin_ready      = w_bin_ready;
  assign avm.avm_write      = w_avm_write;
  assign avm.avm_address    = FB_BASE + fb_offset(w_y, w_x);
  assign avm.avm_writedata  = (r_state == ST_RENDER) ? w_colour : 16'h0000;
  assign avm.avm_byteenable = 2'b11;
  assign busy               = w_busy;
  assign frame_done         = w_frame_done;

endmodule

// File: tb/tb_spectrum_fb_writer.sv
// Randomized bench for spectrum_fb_writer on a reduced frame, scored against a per-pixel reference model.
module tb_spectrum_fb_writer;

  localparam int          NUM_BARS = 8;
  localparam int          BAR_W    = 4;
  localparam int          H_RES    = 40;
  localparam int          V_RES    = 24;
  localparam int          MAG_W    = 16;
  localparam logic [31:0] FB_BASE  = 32'h0010_0000;
  localparam logic [15:0] BAR_RGB  = 16'h07E0;
  localparam logic [15:0] BG_RGB   = 16'h0000;
  localparam int          NPIX     = H_RES * V_RES;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic frame_start = 1'b0;
  logic busy;
  logic frame_done;

  spectrum_bin_if #(.MAG_W(MAG_W)) bin_if ();
  spectrum_avm_if avm_if ();

  spectrum_fb_writer #(
    .NUM_BARS (NUM_BARS),
    .BAR_W    (BAR_W),
    .H_RES    (H_RES),
    .V_RES    (V_RES),
    .MAG_W    (MAG_W),
    .FB_BASE  (FB_BASE),
    .BAR_RGB  (BAR_RGB),
    .BG_RGB   (BG_RGB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .bin         (bin_if),
    .avm         (avm_if),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  logic [15:0] mags [NUM_BARS];
  int          h_m  [NUM_BARS];
  int          pk_m [NUM_BARS];
  logic [15:0] cap  [NPIX];

  // Monitor state
  int          cyc = 0;
  int          exp_k, wr_cnt, order_err, stab_err, ready_err, be_err;
  int          done_cnt, done_cyc, last_acc_cyc;
  logic [31:0] last_addr;
  bit          stall_en = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr;
  logic [15:0] prev_data;

  function automatic logic [15:0] exp_pix(input int x, input int y);
    int bar, row;
    bar = x / BAR_W;
    row = V_RES - 1 - y;
    if (bar >= NUM_BARS) return BG_RGB;
`ifdef SPECTRUM_PEAK_HOLD_EN
    if (pk_m[bar] > 0 && row == pk_m[bar] - 1) return 16'hFFFF;
`endif
    return (row < h_m[bar]) ? BAR_RGB : BG_RGB;
  endfunction

  function automatic logic [15:0] px(input int x, input int y);
    return cap[y * H_RES + x];
  endfunction

  initial begin
    avm_if.avm_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall && (avm_if.avm_write !== 1'b1 || avm_if.avm_address !== prev_addr ||
                           avm_if.avm_writedata !== prev_data))
          stab_err++;
        if (avm_if.avm_write && bin_if.bin_ready) ready_err++;
        if (avm_if.avm_byteenable !== 2'b11) be_err++;
        avm_if.avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        prev_stall = 0;
        if (avm_if.avm_write) begin
          if (avm_if.avm_waitrequest) begin
            prev_stall = 1;
            prev_addr  = avm_if.avm_address;
            prev_data  = avm_if.avm_writedata;
          end else begin
            logic [31:0] off;
            int x, y, idx;
            off = avm_if.avm_address - FB_BASE;
            x   = int'((off >> 1) & 32'h1FF);
            y   = int'(off >> 10);
            idx = y * H_RES + x;
            if (off[0] || x >= H_RES || y >= V_RES || idx != exp_k) order_err++;
            else begin
              cap[idx] = avm_if.avm_writedata;
              exp_k++;
            end
            wr_cnt++;
            last_addr    = avm_if.avm_address;
            last_acc_cyc = cyc;
          end
        end
        if (frame_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic load_frame(input bit stall);
    int i, guard;
    exp_k = 0; wr_cnt = 0; order_err = 0; stab_err = 0; ready_err = 0; be_err = 0;
    done_cnt = 0; done_cyc = -100; last_acc_cyc = 0; last_addr = '0;
    for (int p = 0; p < NPIX; p++) cap[p] = 16'hDEAD;
    stall_en = stall;
    for (int b = 0; b < NUM_BARS; b++) begin
      h_m[b] = int'(mags[b] >> 8);
      if (h_m[b] > V_RES) h_m[b] = V_RES;
`ifdef SPECTRUM_PEAK_HOLD_EN
      pk_m[b] = (pk_m[b] > 0) ? pk_m[b] - 1 : 0;
      if (h_m[b] > pk_m[b]) pk_m[b] = h_m[b];
`endif
    end
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("load_ready", bin_if.bin_ready, 1'b1);
    i = 0;
    guard = 0;
    while (i < NUM_BARS && guard < 1000) begin
      bin_if.bin_valid = ($urandom_range(0, 3) != 0);
      bin_if.bin_mag   = mags[i];
      if (bin_if.bin_valid && bin_if.bin_ready) i++;
      @(negedge clk);
      guard++;
    end
    bin_if.bin_valid = 1'b0;
    chk("load_beats", i, NUM_BARS);
  endtask

  task automatic finish_frame(input string name, input bit noise);
    bit to;
    int bad;
    to = 1;
    for (int c = 0; c < 20000; c++) begin
      if (noise) begin
        frame_start      = ($urandom_range(0, 7) == 0);
        bin_if.bin_valid = 1'b1;
        bin_if.bin_mag   = 16'($urandom);
      end
      @(negedge clk);
      if (frame_done) begin
        to = 0;
        break;
      end
    end
    frame_start = 1'b0;
    bin_if.bin_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({name, "_timeout"}, to, 0);
    chk({name, "_wr_cnt"}, wr_cnt, NPIX);
    chk({name, "_order"}, order_err, 0);
    chk({name, "_stall_stable"}, stab_err, 0);
    chk({name, "_ready_in_render"}, ready_err, 0);
    chk({name, "_byteenable"}, be_err, 0);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_done_latency"}, done_cyc - last_acc_cyc, 1);
    chk({name, "_last_addr"}, last_addr, FB_BASE + ((V_RES - 1) << 10) + ((H_RES - 1) << 1));
    chk({name, "_idle_after"}, busy, 1'b0);
    bad = 0;
    for (int y = 0; y < V_RES; y++)
      for (int x = 0; x < H_RES; x++)
        if (px(x, y) !== exp_pix(x, y)) bad++;
    chk({name, "_pixels"}, bad, 0);
    $display("frame %s: writes=%0d bad_pixels=%0d stall=%0d noise=%0d", name, wr_cnt, bad, stall_en, noise);
  endtask

  initial begin
    for (int b = 0; b < NUM_BARS; b++) begin
      h_m[b] = 0;
      pk_m[b] = 0;
    end
    bin_if.bin_valid = 1'b0;
    bin_if.bin_mag   = '0;

    // Reset with frame_start held: nothing may start.
    frame_start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bin_ready", bin_if.bin_ready, 1'b0);
    chk("rst_avm_write", avm_if.avm_write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_address", avm_if.avm_address, FB_BASE);
    chk("rst_writedata", avm_if.avm_writedata, 16'h0000);
    frame_start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst_busy", busy, 1'b0);
    chk("idle_after_rst_write", avm_if.avm_write, 1'b0);

    // All-zero magnitudes: whole frame background.
    for (int b = 0; b < NUM_BARS; b++) mags[b] = 16'h0000;
    load_frame(0);
    finish_frame("zeros", 0);
    chk("zeros_last_px", px(H_RES - 1, V_RES - 1), BG_RGB);

    // Bar 0 height 10.
    mags[0] = 16'h0A00;
    load_frame(0);
    finish_frame("bar0_h10", 0);
    chk("h10_bottom", px(0, V_RES - 1), BAR_RGB);
    chk("h10_top_row", px(BAR_W - 1, V_RES - 10), BAR_RGB);
    chk("h10_above", px(0, V_RES - 11), BG_RGB);
    chk("h10_next_col", px(BAR_W, V_RES - 1), BG_RGB);

    // Bar 5 clamps to full height, under random stalls.
    for (int b = 0; b < NUM_BARS; b++) mags[b] = 16'h0000;
    mags[5] = 16'hFF00;
    load_frame(1);
    finish_frame("clamp_stall", 0);
    chk("clamp_top_l", px(5 * BAR_W, 0), BAR_RGB);
    chk("clamp_top_r", px(6 * BAR_W - 1, 0), BAR_RGB);
    chk("clamp_right_bg", px(6 * BAR_W, 0), BG_RGB);

    // Random magnitudes, stalls, and frame_start/bin_valid noise during render.
    for (int b = 0; b < NUM_BARS; b++) mags[b] = 16'($urandom);
    load_frame(1);
    finish_frame("random_noise", 1);

    // Reset mid-render abandons the frame.
    for (int b = 0; b < NUM_BARS; b++) mags[b] = 16'($urandom);
    load_frame(1);
    repeat (50) @(negedge clk);
    chk("midrst_writing", avm_if.avm_write, 1'b1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_write_drop", avm_if.avm_write, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_address", avm_if.avm_address, FB_BASE);
    @(negedge clk);
    reset_n = 1'b1;
    stall_en = 0;
    for (int b = 0; b < NUM_BARS; b++) begin
      h_m[b] = 0;
      pk_m[b] = 0;
    end
    repeat (2) @(negedge clk);

    // Height 20 then 0 on bar 0.
    for (int b = 0; b < NUM_BARS; b++) mags[b] = 16'h0000;
    mags[0] = 16'h1400;
    load_frame(0);
    finish_frame("peak_f1", 0);
`ifdef SPECTRUM_PEAK_HOLD_EN
    chk("peak_f1_white", px(0, V_RES - 20), 16'hFFFF);
`else
    chk("peak_f1_bar", px(0, V_RES - 20), BAR_RGB);
`endif
    mags[0] = 16'h0000;
    load_frame(1);
    finish_frame("peak_f2", 0);
`ifdef SPECTRUM_PEAK_HOLD_EN
    chk("peak_f2_white", px(0, V_RES - 19), 16'hFFFF);
`else
    chk("peak_f2_bg", px(0, V_RES - 19), BG_RGB);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
